// File: rtl/dmem_ctrl.sv
// Data-memory front end: sweeps memory to INIT_VALUE after reset, then shares it between two ports round-robin.
// Latency: req sampled in IDLE -> gnt the next cycle -> done the cycle after; one access every 3 cycles.
// Backpressure: a requester holds req/we/addr/wdata until gnt; requests are not served during the init sweep.
// Ports: clk, rst (synchronous, active-low); per port req/we/addr/wdata in and gnt/done/err/rdata out;
//        init_busy status; mem_read/mem_write/mem_a/mem_wd drive the memory, mem_rd is its combinational read data.
module dmem_ctrl #(
    parameter int                DM_ADDRESS = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4198,
    parameter logic [DATA_W-1:0] INIT_VALUE = 32'hAAAAAAAA,
    parameter bit                INIT_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DATA_W-1:0]     wdata0,
    output logic                  gnt0,
    output logic                  done0,
    output logic                  err0,
    output logic [DATA_W-1:0]     rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  gnt1,
    output logic                  done1,
    output logic                  err1,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  init_busy,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [DM_ADDRESS-1:0] LAST_A  = DM_ADDRESS'(DEPTH - 1);
    localparam logic [DM_ADDRESS-1:0] DEPTH_A = DM_ADDRESS'(DEPTH);

    state_t                  state, state_nxt;
    logic [DM_ADDRESS-1:0]   cnt;
    logic                    last_grant;
    logic                    sel;
    logic                    l_we;
    logic [DM_ADDRESS-1:0]   l_addr;
    logic [DATA_W-1:0]       l_wdata;
    logic                    pick;
    logic                    in_range;
    logic [DATA_W-1:0]       acc_rdata;

    // On a tie the port that did not win last time goes; otherwise whichever port asks.
    assign pick      = (req0 && req1) ? ~last_grant : req1;
    assign in_range  = (l_addr < DEPTH_A);
    // Writes and out-of-range accesses return zero read data.
    assign acc_rdata = (in_range && !l_we) ? mem_rd : '0;
    assign init_busy = (state == S_INIT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= INIT_EN ? S_INIT : S_IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            l_we       <= 1'b0;
            l_addr     <= '0;
            l_wdata    <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
            err0       <= 1'b0;
            err1       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_INIT: cnt <= cnt + DM_ADDRESS'(1);
                S_IDLE: begin
                    if (req0 || req1) begin
                        sel     <= pick;
                        l_we    <= pick ? we1 : we0;
                        l_addr  <= pick ? addr1 : addr0;
                        l_wdata <= pick ? wdata1 : wdata0;
                    end
                end
                S_ACCESS: begin
                    last_grant <= sel;
                    if (sel) begin
                        rdata1 <= acc_rdata;
                        err1   <= ~in_range;
                    end else begin
                        rdata0 <= acc_rdata;
                        err0   <= ~in_range;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_a     = '0;
        mem_wd    = '0;
        // Strobes stay low while reset is held so an aborted access never reaches memory or the requester.
        if (rst) begin
            case (state)
                S_INIT: begin
                    mem_write = 1'b1;
                    mem_a     = cnt;
                    mem_wd    = INIT_VALUE;
                    if (cnt == LAST_A) state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    if (req0 || req1) state_nxt = S_ACCESS;
                end
                S_ACCESS: begin
                    gnt0 = ~sel;
                    gnt1 = sel;
                    if (in_range) begin
                        mem_a     = l_addr;
                        mem_write = l_we;
                        mem_read  = ~l_we;
                        mem_wd    = l_we ? l_wdata : '0;
                    end
                    state_nxt = S_RESP;
                end
                S_RESP: begin
                    done0     = ~sel;
                    done1     = sel;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with the init sweep, one without; small behavioural memory behind each.
module tb_dmem_ctrl;
    localparam int          DEPTH = 16;
    localparam logic [31:0] IV    = 32'hAAAAAAAA;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: INIT_EN=1
    logic        rst_a, req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, done0, err0, gnt1, done1, err1, init_busy, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_a, mem_wd, mem_rd;
    logic [31:0] mem [32];
    logic        preload = 1'b1;

    assign mem_rd = mem[mem_a[4:0]];
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 32; i++) mem[i] <= 32'hDEAD0000 | 32'(i);
        else if (mem_write) mem[mem_a[4:0]] <= mem_wd;
    end

    dmem_ctrl #(.DM_ADDRESS(32), .DATA_W(32), .DEPTH(DEPTH), .INIT_VALUE(IV), .INIT_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst_a),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .done0(done0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .done1(done1), .err1(err1), .rdata1(rdata1),
        .init_busy(init_busy), .mem_read(mem_read), .mem_write(mem_write),
        .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Instance B: INIT_EN=0, port 1 tied off, read-only memory returning 0B0B0000|addr
    logic        rst_b, req0_b;
    logic        tie0  = 1'b0;
    logic [31:0] tie32 = '0;
    logic [31:0] addr0_b;
    logic        gnt0_b, done0_b, err0_b, gnt1_b, done1_b, err1_b, busy_b, mrd_b, mwr_b;
    logic [31:0] rdata0_b, rdata1_b, mem_a_b, mem_wd_b, mem_rd_b;
    assign mem_rd_b = 32'h0B0B0000 | mem_a_b;

    dmem_ctrl #(.DM_ADDRESS(32), .DATA_W(32), .DEPTH(DEPTH), .INIT_VALUE(IV), .INIT_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst_b),
        .req0(req0_b), .we0(tie0), .addr0(addr0_b), .wdata0(tie32),
        .gnt0(gnt0_b), .done0(done0_b), .err0(err0_b), .rdata0(rdata0_b),
        .req1(tie0), .we1(tie0), .addr1(tie32), .wdata1(tie32),
        .gnt1(gnt1_b), .done1(done1_b), .err1(err1_b), .rdata1(rdata1_b),
        .init_busy(busy_b), .mem_read(mrd_b), .mem_write(mwr_b),
        .mem_a(mem_a_b), .mem_wd(mem_wd_b), .mem_rd(mem_rd_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expectation pushed when a port is granted, popped on done.
    typedef struct { logic p; logic err; logic [31:0] rd; } sb_t;
    sb_t         sbq[$];
    logic        exp_err [2];
    logic [31:0] exp_rd  [2];

    always @(negedge clk) begin
        if (rst_a === 1'b1) begin
            check("one_hot_strobes", {30'd0, (gnt0 & gnt1) | (done0 & done1), mem_read & mem_write}, 32'd0);
            if (gnt0) sbq.push_back('{1'b0, exp_err[0], exp_rd[0]});
            if (gnt1) sbq.push_back('{1'b1, exp_err[1], exp_rd[1]});
            if (done0 || done1) begin
                if (sbq.size() == 0) begin
                    check("sb_unexpected_done", {done1, done0}, 32'd0);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("sb_port", done1, e.p);
                    check("sb_err", done1 ? err1 : err0, e.err);
                    check("sb_rdata", done1 ? rdata1 : rdata0, e.rd);
                end
            end
        end
    end

    task automatic drive(input logic p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        if (p) begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    endtask

    // One request on instance A, issued in IDLE; returns cycles to gnt and gnt-to-done cycles (0 = timeout).
    task automatic do_req(input logic p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic xe, input logic [31:0] xr, output int lg, output int ld);
        lg = 0;
        ld = 0;
        @(posedge clk); #1;
        exp_err[p] = xe;
        exp_rd[p]  = xr;
        drive(p, 1'b1, we, a, wd);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((p ? gnt1 : gnt0) === 1'b1) begin lg = i; break; end
        end
        if (a < DEPTH) begin
            check("acc_mem_a", mem_a, a);
            check("acc_mem_read", mem_read, !we);
            check("acc_mem_write", mem_write, we);
            check("acc_mem_wd", mem_wd, we ? wd : 32'd0);
        end else begin
            check("oor_mem_rw", {mem_read, mem_write}, 32'd0);
            check("oor_mem_a", mem_a, 32'd0);
        end
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if ((p ? done1 : done0) === 1'b1) begin ld = i; break; end
        end
    endtask

    typedef struct { logic p; logic we; logic [31:0] addr; logic [31:0] wd; logic xe; logic [31:0] xr; } vec_t;
    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end, expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int          lg, ld, ng;
        logic [31:0] hold0, hold1;

        tbl[0] = '{1'b0, 1'b1, 32'd5,  32'h12345678, 1'b0, 32'h0};
        tbl[1] = '{1'b0, 1'b0, 32'd5,  32'h0,        1'b0, 32'h12345678};
        tbl[2] = '{1'b1, 1'b0, 32'd16, 32'h0,        1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 32'd9,  32'hCAFEF00D, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 32'd9,  32'h0,        1'b0, 32'hCAFEF00D};
        tbl[5] = '{1'b1, 1'b0, 32'd15, 32'h0,        1'b0, IV};
        tbl[6] = '{1'b0, 1'b1, 32'd20, 32'h77777777, 1'b1, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 32'd0,  32'h0,        1'b0, IV};

        rst_a = 1'b0; rst_b = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        exp_err[0] = 1'b0; exp_err[1] = 1'b0; exp_rd[0] = '0; exp_rd[1] = '0;
        req0_b = 1'b1; addr0_b = 32'd3;
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        check("rst_init_busy", init_busy, 1);
        check("rst_mem_rw", {mem_read, mem_write}, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_gnt_done", {gnt0, gnt1, done0, done1}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_err", {err0, err1}, 0);
        check("rst_b_init_busy", busy_b, 0);
        check("rst_b_gnt", gnt0_b, 0);

        // INIT_EN=0: req held through reset is granted right after release
        @(posedge clk); #1;
        preload = 1'b0;
        rst_b   = 1'b1;
        @(negedge clk);
        check("b_idle_busy", busy_b, 0);
        check("b_idle_gnt", gnt0_b, 0);
        @(negedge clk);
        check("b_gnt", gnt0_b, 1);
        check("b_mem_read", mrd_b, 1);
        check("b_mem_a", mem_a_b, 3);
        @(posedge clk); #1;
        req0_b = 1'b0;
        @(negedge clk);
        check("b_done", done0_b, 1);
        check("b_rdata", rdata0_b, 32'h0B0B0003);
        check("b_err", err0_b, 0);

        // Init sweep with a port 0 read held throughout
        @(posedge clk); #1;
        exp_err[0] = 1'b0; exp_rd[0] = IV;
        drive(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        rst_a = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("init_write", {init_busy, mem_write, mem_read, gnt0}, 32'b1100);
            check("init_addr", mem_a, i);
            check("init_data", mem_wd, IV);
        end
        @(negedge clk);
        check("init_end_busy", init_busy, 0);
        check("init_end_gnt", gnt0, 0);
        check("init_end_write", mem_write, 0);
        @(negedge clk);
        check("init_first_gnt", gnt0, 1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("init_first_done", done0, 1);
        for (int i = 0; i < 32; i++)
            check("sweep_mem", mem[i], (i < DEPTH) ? IV : (32'hDEAD0000 | 32'(i)));

        // Single-request vectors
        hold0 = IV;
        hold1 = 32'd0;
        for (int k = 0; k < 8; k++) begin
            do_req(tbl[k].p, tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].xe, tbl[k].xr, lg, ld);
            check("vec_gnt_latency", lg, 2);
            check("vec_done_latency", ld, 1);
            if (tbl[k].p) hold1 = tbl[k].xr; else hold0 = tbl[k].xr;
            check("vec_rdata0_hold", rdata0, hold0);
            check("vec_rdata1_hold", rdata1, hold1);
        end
        check("oor_write_blocked", mem[20], 32'hDEAD0014);

        // Contention: both ports held for four accesses
        @(posedge clk); #1;
        exp_err[0] = 1'b0; exp_err[1] = 1'b0;
        exp_rd[0]  = 32'h12345678; exp_rd[1] = 32'hCAFEF00D;
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'd9, 32'd0);
        ng = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                check("cont_order", gnt1, ng % 2);
                check("cont_cycle", i, 2 + 3 * ng);
                ng++;
            end
        end
        check("cont_count", ng, 4);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

        // Reset during ACCESS of a write
        @(posedge clk); #1;
        exp_err[0] = 1'b0; exp_rd[0] = 32'd0;
        drive(1'b0, 1'b1, 1'b1, 32'd2, 32'h55555555);
        lg = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (gnt0 === 1'b1) begin lg = i; break; end
        end
        check("rmo_gnt_latency", lg, 2);
        #1;
        rst_a = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); #1;
        sbq.delete();
        @(negedge clk);
        check("rmo_busy", init_busy, 1);
        check("rmo_no_done", {done0, done1}, 0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        ld = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (init_busy === 1'b0) begin ld = i; break; end
        end
        check("rmo_sweep_len", ld, DEPTH + 1);
        do_req(1'b0, 1'b0, 32'd2, 32'd0, 1'b0, IV, lg, ld);
        check("rmo_read_gnt_latency", lg, 2);
        check("rmo_read_done_latency", ld, 1);

        @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
